// File: rtl/speed_pkg.sv
// Shared speed-ramp definitions: state encoding, data width, default speed clamp.
// Also consumed by the PWM block's testbench.
package speed_pkg;

    localparam int SPEED_W       = 8;
    localparam int MAX_SPEED_DEF = 200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RAMP_DOWN
`ifdef SPEED_RAMP_WDOG_EN
        , ST_TRIP
`endif
    } state_t;

    function automatic state_t dir_of(input logic [SPEED_W-1:0] spd, input logic [SPEED_W-1:0] tgt);
        if (spd < tgt)      return ST_RAMP_UP;
        else if (spd > tgt) return ST_RAMP_DOWN;
        else                return ST_IDLE;
    endfunction

endpackage

// File: rtl/speed_tick_det.sv
// Rising-edge detect of the PWM period strobe; tick is valid in the cycle speed_rdy rises.
// Latency: combinational from the input against one registered history bit; no backpressure.
module speed_tick_det (
    input  logic clk,
    input  logic rst_n,
    input  logic speed_rdy,
    output logic tick
);

    logic rdy_q;
    logic rdy_d;

    always_comb rdy_d = speed_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= rdy_d;
    end

    assign tick = speed_rdy & ~rdy_q;

endmodule

// File: rtl/speed_ramp.sv
// Ramps speed_out toward the last commanded target by STEP per PWM period; optional
// watchdog (SPEED_RAMP_WDOG_EN) forces target 0 after WDOG_PERIODS idle periods. Always ready.
import speed_pkg::*;

module speed_ramp #(
    parameter int STEP         = 4,
    parameter int MAX_SPEED    = MAX_SPEED_DEF,
    parameter int WDOG_PERIODS = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic               speed_rdy,
    output logic [SPEED_W-1:0] speed_out,
    output logic               at_target,
    output logic               wdog_trip
);

    localparam logic [SPEED_W-1:0] MAX_L  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W:0]   STEP_9 = (SPEED_W+1)'(STEP);

    if (STEP < 1 || STEP > 50 || WDOG_PERIODS < 1 || WDOG_PERIODS > 255) begin : g_bad_cfg
        $error("speed_ramp: STEP or WDOG_PERIODS out of range");
    end

    logic               tick;
    logic               accept;
    logic [SPEED_W-1:0] cmd_clamped;
    logic [SPEED_W:0]   up_sum;
    logic [SPEED_W:0]   dn_diff;

    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] target_q, target_d;
    state_t             state_q, state_d;
    logic               at_target_q, at_target_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               trip_q, trip_d;
`ifdef SPEED_RAMP_WDOG_EN
    localparam logic [7:0] WD_L = 8'(WDOG_PERIODS);
    logic [7:0]         wdog_cnt_q, wdog_cnt_d;
`endif

    speed_tick_det u_tick_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .speed_rdy (speed_rdy),
        .tick      (tick)
    );

    always_comb begin
        accept      = cmd_valid & cmd_ready_q;
        cmd_clamped = (cmd_speed > MAX_L) ? MAX_L : cmd_speed;
        up_sum      = {1'b0, speed_q} + STEP_9;
        dn_diff     = {1'b0, speed_q} - STEP_9;
        cmd_ready_d = 1'b1;
        trip_d      = trip_q;

        // The tick steps against the target held before this edge; a command in the same
        // cycle only lands in target_q and steers the following tick.
        speed_d = speed_q;
        if (tick) begin
            case (state_q)
                ST_RAMP_UP:
                    speed_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[SPEED_W-1:0];
`ifdef SPEED_RAMP_WDOG_EN
                ST_RAMP_DOWN, ST_TRIP:
`else
                ST_RAMP_DOWN:
`endif
                    speed_d = ($signed(dn_diff) < $signed({1'b0, target_q})) ? target_q
                                                                             : dn_diff[SPEED_W-1:0];
                default: speed_d = speed_q;
            endcase
        end

        target_d = accept ? cmd_clamped : target_q;

`ifdef SPEED_RAMP_WDOG_EN
        wdog_cnt_d = wdog_cnt_q;
        if (accept) begin
            trip_d     = 1'b0;
            wdog_cnt_d = '0;
        end else if (tick && !trip_q) begin
            wdog_cnt_d = wdog_cnt_q + 8'd1;
            if (wdog_cnt_d == WD_L) begin
                trip_d   = 1'b1;
                target_d = '0;
            end
        end
        state_d = trip_d ? ST_TRIP : dir_of(speed_d, target_d);
`else
        state_d = dir_of(speed_d, target_d);
`endif
        at_target_d = (speed_d == target_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q     <= '0;
            target_q    <= '0;
            state_q     <= ST_IDLE;
            at_target_q <= 1'b1;
            cmd_ready_q <= 1'b0;
            trip_q      <= 1'b0;
`ifdef SPEED_RAMP_WDOG_EN
            wdog_cnt_q  <= '0;
`endif
        end else begin
            speed_q     <= speed_d;
            target_q    <= target_d;
            state_q     <= state_d;
            at_target_q <= at_target_d;
            cmd_ready_q <= cmd_ready_d;
            trip_q      <= trip_d;
`ifdef SPEED_RAMP_WDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
`endif
        end
    end

    assign speed_out = speed_q;
    assign at_target = at_target_q;
    assign cmd_ready = cmd_ready_q;
`ifdef SPEED_RAMP_WDOG_EN
    assign wdog_trip = trip_q;
`else
    assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_speed_ramp.sv
// Bench for speed_ramp: directed literal scenarios plus randomized traffic checked each cycle
// against a behavioural model of the ramp/clamp/watchdog rules.
module tb_speed_ramp;

    localparam int STEP = 4;
    localparam int MAXS = 200;
    localparam int WD   = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_speed;
    logic       speed_rdy;
    logic [7:0] speed_out;
    logic       at_target;
    logic       wdog_trip;

    int checks   = 0;
    int failures = 0;

    speed_ramp #(.STEP(STEP), .MAX_SPEED(MAXS), .WDOG_PERIODS(WD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .speed_rdy (speed_rdy),
        .speed_out (speed_out),
        .at_target (at_target),
        .wdog_trip (wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the rules.
    int m_speed, m_target, m_cnt;
    bit m_trip, m_prev, m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_speed = 0; m_target = 0; m_cnt = 0;
            m_trip = 0; m_prev = 0; m_ready = 0;
        end else begin
            bit acc, tk;
            int nt;
            acc = cmd_valid && m_ready;
            tk  = speed_rdy && !m_prev;
            if (tk) begin
                if (m_speed < m_target)
                    m_speed = (m_speed + STEP > m_target) ? m_target : m_speed + STEP;
                else if (m_speed > m_target)
                    m_speed = (m_speed - STEP < m_target) ? m_target : m_speed - STEP;
            end
            nt = acc ? ((int'(cmd_speed) > MAXS) ? MAXS : int'(cmd_speed)) : m_target;
`ifdef SPEED_RAMP_WDOG_EN
            if (acc) begin
                m_trip = 0; m_cnt = 0;
            end else if (tk && !m_trip) begin
                m_cnt++;
                if (m_cnt == WD) begin
                    m_trip = 1; nt = 0;
                end
            end
`endif
            m_target = nt;
            m_prev   = speed_rdy;
            m_ready  = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("speed_out", int'(speed_out), m_speed);
        chk("at_target", int'(at_target), int'(m_speed == m_target));
        chk("cmd_ready", int'(cmd_ready), int'(m_ready));
        chk("wdog_trip", int'(wdog_trip), int'(m_trip));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input int v);
        cmd_valid = 1'b1;
        cmd_speed = 8'(v);
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    task automatic do_tick(input int hi, input int period);
        speed_rdy = 1'b1;
        cyc(hi);
        speed_rdy = 1'b0;
        cyc(period - hi);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_speed = '0; speed_rdy = 1'b0;
        cyc(3);
        chk("rst_speed", int'(speed_out), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_wdog", int'(wdog_trip), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("ready_after_rst", int'(cmd_ready), 1);

        // Ramp 0 -> 100 with the full PWM period.
        send_cmd(100);
        cyc(1);
        chk("at_target_pre_ramp", int'(at_target), 0);
        for (int k = 1; k <= 25; k++) begin
            do_tick(3, 607);
            chk("ramp100_step", int'(speed_out), 4 * k);
        end
        chk("ramp100_at_target", int'(at_target), 1);

        // Clamp: 250 -> 200.
        send_cmd(250);
        for (int k = 0; k < 27; k++) do_tick(2, 8);
        chk("clamp_speed", int'(speed_out), 200);
        chk("clamp_at_target", int'(at_target), 1);

        // Down to 6, then 6 -> 2 -> 0 without underflow.
        send_cmd(6);
        for (int k = 0; k < 49; k++) do_tick(2, 6);
        chk("down_to_6", int'(speed_out), 6);
        send_cmd(0);
        do_tick(2, 6); chk("down_2", int'(speed_out), 2);
        do_tick(2, 6); chk("down_0", int'(speed_out), 0);
        do_tick(2, 6); chk("down_hold_0", int'(speed_out), 0);

        // Command coincident with a tick: the tick still uses the old target.
        send_cmd(20);
        for (int k = 0; k < 3; k++) do_tick(2, 6);
        chk("pre_same_cycle", int'(speed_out), 12);
        speed_rdy = 1'b1; cmd_valid = 1'b1; cmd_speed = 8'd0;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        speed_rdy = 1'b0;
        cyc(3);
        chk("same_cycle_old_target", int'(speed_out), 16);
        do_tick(2, 6);
        chk("same_cycle_new_dir", int'(speed_out), 12);

        // A held strobe gives one step only.
        do_tick(10, 14);
        chk("held_rdy_one_step", int'(speed_out), 8);

        // Asynchronous reset mid-ramp.
        send_cmd(200);
        do_tick(2, 6); do_tick(2, 6);
        chk("pre_async_rst", int'(speed_out), 16);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_rst_speed", int'(speed_out), 0);
        chk("async_rst_at_target", int'(at_target), 1);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

`ifdef SPEED_RAMP_WDOG_EN
        send_cmd(40);
        for (int k = 0; k < WD + 10; k++) do_tick(2, 5);
        chk("wdog_tripped", int'(wdog_trip), 1);
        chk("wdog_speed_0", int'(speed_out), 0);
        send_cmd(20);
        chk("wdog_cleared", int'(wdog_trip), 0);
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            speed_rdy = ($urandom_range(0, 3) == 0);
            cmd_valid = ($urandom_range(0, 19) == 0);
            cmd_speed = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cyc(1);
        end
        rst_n = 1'b1; cmd_valid = 1'b0; speed_rdy = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
